// File: rtl/uart_monitor_pkg.sv
// Shared types for the UART receive monitor: FSM state encoding, parity
// mode constants, the sticky error-flag bundle and small bit-level helpers.
package uart_monitor_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic exit_seen;
        logic frame_err;
        logic parity_err;
        logic overflow;
    } err_flags_t;

    // Parity bit a well-formed frame carries for data d (zero-extended to 9 bits).
    function automatic logic parity_bit(input logic [8:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// First-word-fall-through receive FIFO with push/pop and full/empty/level status.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_mon_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero when empty so reset and idle present a clean bus.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receiver feeding a character FIFO, with sticky exit/frame/parity/overflow flags.
// Define UART_RX_MONITOR_MAJORITY_EN for 2-of-3 majority voting around mid-bit.
module uart_rx_monitor
    import uart_monitor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 862,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int EXIT_CODE    = 'hFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          exit_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    input  logic                          clr_i
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]        BIT_WAIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [DATA_BITS-1:0] EXIT_CHAR = DATA_BITS'(EXIT_CODE);
`ifdef UART_RX_MONITOR_MAJORITY_EN
    // One cycle later than plain sampling so the mid+1 sample exists at decision time.
    localparam logic [CW-1:0] START_WAIT = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] START_WAIT = CW'(CLKS_PER_BIT / 2 - 1);
`endif

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  stop_bad_q, stop_bad_d;
    err_flags_t            flags_q, flags_d;
    logic                  rx_s1_q, rx_s2_q, rx_s3_q;
    logic                  bit_s, tick;
    logic                  wr_req, set_frame, set_parity;
    logic                  fifo_full, fifo_empty, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_i;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

`ifdef UART_RX_MONITOR_MAJORITY_EN
    logic rx_s4_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_s4_q <= 1'b1;
        else        rx_s4_q <= rx_s3_q;
    end
    assign bit_s = maj3(rx_s2_q, rx_s3_q, rx_s4_q);
`else
    assign bit_s = rx_s2_q;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        stop_bad_d = stop_bad_q;
        wr_req     = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    state_d = ST_START;
                    cnt_d   = START_WAIT;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (bit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    cnt_d     = BIT_WAIT;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = BIT_WAIT;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d  = '0;
                        stop_bad_d = 1'b0;
                        state_d    = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d      = BIT_WAIT;
                    state_d    = ST_STOP;
                    set_parity = (bit_s != parity_bit(9'(shreg_q), PARITY_MODE));
                end
            end
            ST_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = BIT_WAIT;
                    if (!bit_s) begin
                        set_frame  = 1'b1;
                        stop_bad_d = 1'b1;
                    end
                    // Commit on the last stop sample only if every stop bit was high.
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                        wr_req    = bit_s && !stop_bad_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop = valid_o && ready_i;

    always_comb begin
        flags_d = clr_i ? '0 : flags_q;
        if (set_frame)                                flags_d.frame_err  = 1'b1;
        if (set_parity)                               flags_d.parity_err = 1'b1;
        if (wr_req && fifo_full && !pop)              flags_d.overflow   = 1'b1;
        if (wr_req && (shreg_q == EXIT_CHAR))         flags_d.exit_seen  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            stop_bad_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            stop_bad_q <= stop_bad_d;
            flags_q    <= flags_d;
        end
    end

    uart_mon_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_req),
        .wdata_i (shreg_q),
        .pop_i   (pop),
        .rdata_o (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign valid_o      = !fifo_empty;
    assign exit_o       = flags_q.exit_seen;
    assign frame_err_o  = flags_q.frame_err;
    assign parity_err_o = flags_q.parity_err;
    assign overflow_o   = flags_q.overflow;

endmodule
